rv32_inst_encoder: RTL and testbench
====================================

Name: rv32_inst_encoder

Overview:
Inverse of the rv32 field decode. It accepts decoded instruction fields and packs them into a 32-bit RV32I instruction word. The opcode selects the format (R/I/S/B/U/J). It is a 2-stage elastic valid/ready pipeline, used by the test-stimulus generator and the self-modifying-code / trap-vector patch path ahead of instruction memory writes.

Parameters:
- PIPE_STAGES, 2, number of register slices: 1 merges classify+pack into one stage; 2 is the default.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept bundle
- in_opcode  in  7  rv32_opcode_t
- in_rd, in_rs1, in_rs2  in  5 each  rv32_reg_addr_t
- in_funct3  in  3  rv32_funct3_t
- in_funct7  in  7  rv32_funct7_t
- in_imm  in  32  rv32_imm_t, already sign-extended byte offset / value
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts
- out_inst  out  32  rv32_inst_t
- out_format  out  3  rv32_format_t of the emitted word
- out_encode_error  out  1  unknown opcode or unrepresentable immediate

Behaviour:
- Reset (async assert, sync release): all stage valid flags clear; out_valid=0, out_inst=0, out_format=FMT_R, out_encode_error=0; in_ready=1 one cycle after release.
- Handshake: transfer on valid&&ready. Each stage has ready = !valid_q || next_ready. No combinational in_valid->out_valid path. in_ready depends only on registered state and out_ready.
- Latency: PIPE_STAGES cycles from input transfer to out_valid. Full throughput: 1 word/cycle when out_ready is held high.
- Stage 1 (classify): map opcode to format.
  - LUI/AUIPC -> U
  - JAL -> J
  - JALR/LOAD/OP-IMM/SYSTEM/MISC-MEM -> I
  - STORE -> S
  - BRANCH -> B
  - OP -> R
  - anything else -> FMT_BAD; error=1, out_inst=0.
- Stage 2 (pack, standard RV32 bit positions):
  - R = funct7|rs2|rs1|funct3|rd|op
  - I = imm[11:0]|rs1|funct3|rd|op
  - S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|op
  - B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op
  - U = imm[31:12]|rd|op
  - J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Unused fields for a format are ignored (e.g. rs2 for I-type).
- Backpressure: out_ready low holds out_* stable until accepted. Up to PIPE_STAGES words buffered; then in_ready=0.
- Simultaneous accept and new input on a full pipe: both occur, no bubble.
- Reset mid-operation: in-flight words are dropped and never emitted.

Optional Feature:
- RV32_ENCODER_STRICT_EN
- Defined: range checks set out_encode_error; the word is still packed from the truncated bits.
  - I/S: imm not the sign-extension of imm[11:0].
  - B: imm not the sign-extension of imm[12:0], or imm[0]!=0.
  - J: imm not the sign-extension of imm[20:0], or imm[0]!=0.
  - U: imm[11:0]!=0.
- Undefined: immediates are silently truncated; out_encode_error is set only for FMT_BAD.

Decomposition:
- rv32 package gains:
  - rv32_format_t enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD)
  - opcode localparams (RV32_OP_LUI=7'h37, AUIPC=7'h17, JAL=7'h6F, JALR=7'h67, BRANCH=7'h63, LOAD=7'h03, STORE=7'h23, OP_IMM=7'h13, OP=7'h33, MISC_MEM=7'h0F, SYSTEM=7'h73)
- Pure function rv32_format_of(opcode) in the package.
- One sub-module: rv32_pipe_slice, a parameterised-width valid/ready register slice instantiated per stage.

Test Plan:
- addi x1,x0,5: opcode 0x13, rd=1, rs1=0, f3=0, imm=5 -> out_inst=0x00500093, format I, error=0, after 2 cycles.
- add x3,x1,x2: opcode 0x33, f7=0 -> 0x002081B3. Then sw x2,8(x1): opcode 0x23, f3=2 -> 0x0020A423. Sent on back-to-back cycles; outputs on back-to-back cycles.
- beq x0,x0,-4: imm=0xFFFFFFFC -> 0xFE000EE3. lui x5: imm=0x12345000 -> 0x123452B7.
- Branch imm=3 -> error=1 with STRICT_EN; error=0 and inst=0x00000163 without it. Opcode 0x7F -> error=1, inst=0 in both builds.
- Stream of 6 words with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 buffered; all 6 words emitted in order with no duplicates, and out_* stay stable while stalled.
- rst_n asserted with 2 words in flight -> out_valid=0 immediately; after release no stale word appears; the next input encodes correctly.

Source files
------------

// File: rtl/rv32_inst_encoder_pkg.sv
// rtl/rv32_inst_encoder_pkg.sv - rv32 field types, opcodes, format classify and pack helpers
// Optional build macro: RV32_ENCODER_STRICT_EN (immediate range checks raise the encode error)
package rv32_inst_encoder_pkg;

    typedef logic [6:0]  rv32_opcode_t;
    typedef logic [4:0]  rv32_reg_addr_t;
    typedef logic [2:0]  rv32_funct3_t;
    typedef logic [6:0]  rv32_funct7_t;
    typedef logic [31:0] rv32_imm_t;
    typedef logic [31:0] rv32_inst_t;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_BAD = 3'd6
    } rv32_format_t;

    localparam rv32_opcode_t RV32_OP_LUI      = 7'h37;
    localparam rv32_opcode_t RV32_OP_AUIPC    = 7'h17;
    localparam rv32_opcode_t RV32_OP_JAL      = 7'h6F;
    localparam rv32_opcode_t RV32_OP_JALR     = 7'h67;
    localparam rv32_opcode_t RV32_OP_BRANCH   = 7'h63;
    localparam rv32_opcode_t RV32_OP_LOAD     = 7'h03;
    localparam rv32_opcode_t RV32_OP_STORE    = 7'h23;
    localparam rv32_opcode_t RV32_OP_OP_IMM   = 7'h13;
    localparam rv32_opcode_t RV32_OP_OP       = 7'h33;
    localparam rv32_opcode_t RV32_OP_MISC_MEM = 7'h0F;
    localparam rv32_opcode_t RV32_OP_SYSTEM   = 7'h73;

    typedef struct packed {
        rv32_opcode_t   opcode;
        rv32_reg_addr_t rd;
        rv32_reg_addr_t rs1;
        rv32_reg_addr_t rs2;
        rv32_funct3_t   funct3;
        rv32_funct7_t   funct7;
        rv32_imm_t      imm;
    } rv32_fields_t;

    typedef struct packed {
        rv32_fields_t fields;
        rv32_format_t fmt;
        logic         err;
    } rv32_classified_t;

    typedef struct packed {
        rv32_inst_t   inst;
        rv32_format_t fmt;
        logic         err;
    } rv32_encoded_t;

    function automatic rv32_format_t rv32_format_of(input rv32_opcode_t opcode);
        case (opcode)
            RV32_OP_LUI, RV32_OP_AUIPC:                   return FMT_U;
            RV32_OP_JAL:                                  return FMT_J;
            RV32_OP_JALR, RV32_OP_LOAD, RV32_OP_OP_IMM,
            RV32_OP_SYSTEM, RV32_OP_MISC_MEM:             return FMT_I;
            RV32_OP_STORE:                                return FMT_S;
            RV32_OP_BRANCH:                               return FMT_B;
            RV32_OP_OP:                                   return FMT_R;
            default:                                      return FMT_BAD;
        endcase
    endfunction

    // True when the immediate cannot be carried losslessly by the format's field.
    function automatic logic rv32_imm_range_error(input rv32_format_t fmt, input rv32_imm_t imm);
        case (fmt)
            FMT_I, FMT_S: return imm != {{20{imm[11]}}, imm[11:0]};
            FMT_B:        return (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
            FMT_J:        return (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
            FMT_U:        return imm[11:0] != 12'd0;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic rv32_classified_t rv32_classify(input rv32_fields_t f);
        rv32_classified_t c;
        c.fields = f;
        c.fmt    = rv32_format_of(f.opcode);
        c.err    = (c.fmt == FMT_BAD);
`ifdef RV32_ENCODER_STRICT_EN
        c.err    = c.err | rv32_imm_range_error(c.fmt, f.imm);
`endif
        return c;
    endfunction

    function automatic rv32_encoded_t rv32_pack(input rv32_classified_t c);
        rv32_encoded_t e;
        rv32_fields_t  f;
        f      = c.fields;
        e.fmt  = c.fmt;
        e.err  = c.err;
        case (c.fmt)
            FMT_R:   e.inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I:   e.inst = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S:   e.inst = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            FMT_B:   e.inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                               f.imm[4:1], f.imm[11], f.opcode};
            FMT_U:   e.inst = {f.imm[31:12], f.rd, f.opcode};
            FMT_J:   e.inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            default: e.inst = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/rv32_inst_encoder_if.sv
// rtl/rv32_inst_encoder_if.sv - field-bundle input and encoded-word output handshake bundle
interface rv32_inst_encoder_if;
    import rv32_inst_encoder_pkg::*;

    logic           in_valid;
    logic           in_ready;
    rv32_opcode_t   in_opcode;
    rv32_reg_addr_t in_rd;
    rv32_reg_addr_t in_rs1;
    rv32_reg_addr_t in_rs2;
    rv32_funct3_t   in_funct3;
    rv32_funct7_t   in_funct7;
    rv32_imm_t      in_imm;
    logic           out_valid;
    logic           out_ready;
    rv32_inst_t     out_inst;
    rv32_format_t   out_format;
    logic           out_encode_error;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_inst, out_format, out_encode_error
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_inst, out_format, out_encode_error
    );
endinterface

// File: rtl/rv32_pipe_slice.sv
// rtl/rv32_pipe_slice.sv - one-entry valid/ready register slice, full throughput
module rv32_pipe_slice #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Accept while empty or while the held word leaves this same cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: rtl/rv32_inst_encoder.sv
// rtl/rv32_inst_encoder.sv - packs decoded rv32 fields into an RV32I word over an elastic pipe
// Optional build macro: RV32_ENCODER_STRICT_EN (see package)
module rv32_inst_encoder
    import rv32_inst_encoder_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32_inst_encoder_if.slave   bus
);
    rv32_fields_t  in_fields;
    rv32_encoded_t enc_q;

    assign in_fields.opcode = bus.in_opcode;
    assign in_fields.rd     = bus.in_rd;
    assign in_fields.rs1    = bus.in_rs1;
    assign in_fields.rs2    = bus.in_rs2;
    assign in_fields.funct3 = bus.in_funct3;
    assign in_fields.funct7 = bus.in_funct7;
    assign in_fields.imm    = bus.in_imm;

    assign bus.out_inst         = enc_q.inst;
    assign bus.out_format       = enc_q.fmt;
    assign bus.out_encode_error = enc_q.err;

    generate
        if (PIPE_STAGES == 1) begin : g_one_stage
            rv32_encoded_t enc_d;
            assign enc_d = rv32_pack(rv32_classify(in_fields));

            rv32_pipe_slice #(.WIDTH($bits(rv32_encoded_t))) u_slice (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (bus.in_valid),
                .in_ready  (bus.in_ready),
                .in_data   (enc_d),
                .out_valid (bus.out_valid),
                .out_ready (bus.out_ready),
                .out_data  (enc_q)
            );
        end else begin : g_two_stage
            rv32_classified_t cls_d;
            rv32_classified_t cls_q;
            rv32_encoded_t    enc_d;
            logic             cls_valid;
            logic             pack_ready;

            assign cls_d = rv32_classify(in_fields);
            assign enc_d = rv32_pack(cls_q);

            rv32_pipe_slice #(.WIDTH($bits(rv32_classified_t))) u_classify (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (bus.in_valid),
                .in_ready  (bus.in_ready),
                .in_data   (cls_d),
                .out_valid (cls_valid),
                .out_ready (pack_ready),
                .out_data  (cls_q)
            );

            rv32_pipe_slice #(.WIDTH($bits(rv32_encoded_t))) u_pack (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (cls_valid),
                .in_ready  (pack_ready),
                .in_data   (enc_d),
                .out_valid (bus.out_valid),
                .out_ready (bus.out_ready),
                .out_data  (enc_q)
            );
        end
    endgenerate
endmodule

// File: tb/tb_rv32_inst_encoder.sv
// tb/tb_rv32_inst_encoder.sv - directed self-checking bench for rv32_inst_encoder
module tb_rv32_inst_encoder;
    import rv32_inst_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv32_inst_encoder_if bus();

    rv32_inst_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef RV32_ENCODER_STRICT_EN
    localparam logic STRICT = 1'b1;
`else
    localparam logic STRICT = 1'b0;
`endif

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm);
        bus.in_opcode = op;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_imm    = imm;
    endtask

    // Drives one bundle, returns the emitted word and the cycles from transfer to out_valid.
    task automatic encode_one(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, output logic [31:0] inst,
                              output logic [2:0] fmt, output logic err, output int lat);
        lat  = -1;
        inst = '0;
        fmt  = '0;
        err  = 1'b0;
        @(negedge clk);
        set_fields(op, rd, rs1, rs2, f3, f7, imm);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        for (int n = 0; n < 20 && !bus.in_ready; n++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        for (int c = 1; c <= 20; c++) begin
            if (bus.out_valid) begin
                lat  = c;
                inst = bus.out_inst;
                fmt  = bus.out_format;
                err  = bus.out_encode_error;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_fields('0, '0, '0, '0, '0, '0, '0);
        #22;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst got %h want 00000000", bus.out_inst); end
        checks++; if (bus.out_format !== FMT_R) begin errors++; $display("FAIL reset_out_format got %0d want %0d", bus.out_format, FMT_R); end
        checks++; if (bus.out_encode_error !== 1'b0) begin errors++; $display("FAIL reset_out_error got %b want 0", bus.out_encode_error); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_addi_latency;
        logic [31:0] inst; logic [2:0] fmt; logic err; int lat;
        encode_one(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, inst, fmt, err, lat);
        checks++; if (inst !== 32'h00500093) begin errors++; $display("FAIL addi_inst got %h want 00500093", inst); end
        checks++; if (fmt !== FMT_I) begin errors++; $display("FAIL addi_format got %0d want %0d", fmt, FMT_I); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL addi_error got %b want 0", err); end
        checks++; if (lat != 2) begin errors++; $display("FAIL addi_latency got %0d want 2", lat); end
    endtask

    task automatic test_formats;
        logic [31:0] inst; logic [2:0] fmt; logic err; int lat;
        encode_one(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, inst, fmt, err, lat);
        checks++; if (inst !== 32'hFE000EE3) begin errors++; $display("FAIL beq_inst got %h want FE000EE3", inst); end
        checks++; if (fmt !== FMT_B || err !== 1'b0) begin errors++; $display("FAIL beq_fmt_err got %0d/%b want %0d/0", fmt, err, FMT_B); end
        encode_one(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, inst, fmt, err, lat);
        checks++; if (inst !== 32'h123452B7) begin errors++; $display("FAIL lui_inst got %h want 123452B7", inst); end
        checks++; if (fmt !== FMT_U || err !== 1'b0) begin errors++; $display("FAIL lui_fmt_err got %0d/%b want %0d/0", fmt, err, FMT_U); end
        encode_one(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, inst, fmt, err, lat);
        checks++; if (inst !== 32'h001000EF) begin errors++; $display("FAIL jal_inst got %h want 001000EF", inst); end
        checks++; if (fmt !== FMT_J || err !== 1'b0) begin errors++; $display("FAIL jal_fmt_err got %0d/%b want %0d/0", fmt, err, FMT_J); end
        encode_one(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, inst, fmt, err, lat);
        checks++; if (inst !== 32'h402081B3) begin errors++; $display("FAIL sub_inst got %h want 402081B3", inst); end
        checks++; if (fmt !== FMT_R || err !== 1'b0) begin errors++; $display("FAIL sub_fmt_err got %0d/%b want %0d/0", fmt, err, FMT_R); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.out_ready = 1'b1;
        set_fields(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        set_fields(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h002081B3) begin errors++; $display("FAIL b2b_add got v=%b %h want v=1 002081B3", bus.out_valid, bus.out_inst); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h0020A423 || bus.out_format !== FMT_S) begin errors++; $display("FAIL b2b_sw got v=%b %h f=%0d want v=1 0020A423 f=%0d", bus.out_valid, bus.out_inst, bus.out_format, FMT_S); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_errors;
        logic [31:0] inst; logic [2:0] fmt; logic err; int lat;
        encode_one(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, inst, fmt, err, lat);
        checks++; if (inst !== 32'h00000163) begin errors++; $display("FAIL odd_branch_inst got %h want 00000163", inst); end
        checks++; if (err !== STRICT) begin errors++; $display("FAIL odd_branch_error got %b want %b", err, STRICT); end
        encode_one(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, inst, fmt, err, lat);
        checks++; if (inst !== 32'h80000093 || err !== STRICT) begin errors++; $display("FAIL wide_addi got %h/%b want 80000093/%b", inst, err, STRICT); end
        encode_one(7'h7F, 5'd1, 5'd2, 5'd3, 3'd4, 7'h55, 32'h12345678, inst, fmt, err, lat);
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL bad_op_inst got %h want 00000000", inst); end
        checks++; if (err !== 1'b1 || fmt !== FMT_BAD) begin errors++; $display("FAIL bad_op_err_fmt got %b/%0d want 1/%0d", err, fmt, FMT_BAD); end
    endtask

    task automatic test_backpressure_stream;
        logic [31:0] expected [6];
        logic [31:0] held;
        logic        prev_stall;
        logic        want_ready;
        int          sent, recv, cyc, ready_low, extra;
        for (int i = 0; i < 6; i++) expected[i] = 32'h00000093 | (32'(i + 1) << 20);
        sent = 0; recv = 0; cyc = 0; ready_low = 0; prev_stall = 1'b0; held = '0;
        while (recv < 6 && cyc < 60) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 3 && cyc < 6);
            if (sent < 6) begin
                set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent + 1));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            want_ready = ((sent - recv) < 2) || bus.out_ready;
            checks++; if (bus.in_ready !== want_ready) begin errors++; $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, bus.in_ready, want_ready); end
            if (!bus.in_ready) ready_low++;
            if (prev_stall) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== held) begin errors++; $display("FAIL stream_stall_stable cyc %0d got v=%b %h want v=1 %h", cyc, bus.out_valid, bus.out_inst, held); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++; if (bus.out_inst !== expected[recv]) begin errors++; $display("FAIL stream_word%0d got %h want %h", recv, bus.out_inst, expected[recv]); end
                recv++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = bus.out_inst;
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        checks++; if (recv != 6) begin errors++; $display("FAIL stream_count got %0d want 6", recv); end
        checks++; if (ready_low == 0) begin errors++; $display("FAIL stream_in_ready_drop got %0d low cycles want >0", ready_low); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.out_valid) extra++;
            @(negedge clk);
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL stream_duplicates got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_reset_midflight;
        logic [31:0] inst; logic [2:0] fmt; logic err; int lat, stale;
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        bus.in_valid = 1'b1;
        @(negedge clk);
        set_fields(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_inst !== 32'h00700093) begin errors++; $display("FAIL midflight_loaded got v=%b %h want v=1 00700093", bus.out_valid, bus.out_inst); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midflight_async_clear got %b want 0", bus.out_valid); end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.out_valid) stale++;
            @(negedge clk);
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL midflight_stale got %0d valid cycles want 0", stale); end
        encode_one(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, inst, fmt, err, lat);
        checks++; if (inst !== 32'h00900093 || lat != 2) begin errors++; $display("FAIL midflight_next got %h lat %0d want 00900093 lat 2", inst, lat); end
    endtask

    initial begin
        test_reset();
        test_addi_latency();
        test_formats();
        test_back_to_back();
        test_errors();
        test_backpressure_stream();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end
endmodule
